// File: rtl/rr_output_port_arbiter.sv
// Per-output wormhole arbiter: round-robin grant held until the tail flit is
// forwarded, with downstream credit tracking and a stall watchdog.
module rr_output_port_arbiter #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  req,
  input  logic [4:0]  flit_valid,
  input  logic [14:0] flit_id,
  input  logic        credit_in,
  output logic [4:0]  grant,
  output logic [2:0]  sel,
  output logic        busy,
  output logic        fwd,
  output logic [2:0]  credits,
  output logic        timeout,
  output logic        credit_err
);

  localparam logic [2:0] DEPTH_C   = 3'(DEPTH);
  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);
  localparam logic [2:0] SEL_IDLE  = 3'b111;

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t     state, state_next;
  logic [4:0] grant_next;
  logic [2:0] sel_next;
  logic [2:0] ptr, ptr_next;
  logic [2:0] credits_next;
  logic [7:0] stall_cnt, stall_next;
  logic       timeout_next;
  logic       credit_err_next;

  logic       win_found;
  logic [2:0] win_idx;
  logic [3:0] cand;
  logic       fwd_valid;
  logic       is_tail;
  logic [2:0] ptr_after;
  logic [7:0] stall_inc;

  // Scan ptr, ptr+1, ... modulo 5 and take the first requester.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned k = 0; k < 5; k++) begin
      cand = {1'b0, ptr} + 4'(k);
      if (cand >= 4'd5) cand = cand - 4'd5;
      if (!win_found && req[cand[2:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[2:0];
      end
    end
  end

  // grant is one-hot (zero when idle), so masking selects the granted input.
  assign fwd_valid = |(flit_valid & grant);
  assign is_tail   = |(grant & {flit_id[14], flit_id[11], flit_id[8], flit_id[5], flit_id[2]});
  assign fwd       = (state == BUSY) && fwd_valid && (credits != '0);
  assign busy      = (state == BUSY);
  assign ptr_after = (sel == 3'd4) ? 3'd0 : sel + 3'd1;
  assign stall_inc = stall_cnt + 8'd1;

  always_comb begin
    state_next   = state;
    grant_next   = grant;
    sel_next     = sel;
    ptr_next     = ptr;
    stall_next   = stall_cnt;
    timeout_next = 1'b0;
    case (state)
      IDLE: begin
        stall_next = '0;
        if (win_found) begin
          state_next = BUSY;
          grant_next = 5'b00001 << win_idx;
          sel_next   = win_idx;
        end
      end
      BUSY: begin
        if (fwd) begin
          stall_next = '0;
          if (is_tail) begin
            state_next = IDLE;
            grant_next = '0;
            sel_next   = SEL_IDLE;
            ptr_next   = ptr_after;
          end
        end else if (stall_inc == TIMEOUT_C) begin
          // Forwarding the tail takes precedence, hence only reached when !fwd.
          state_next   = IDLE;
          grant_next   = '0;
          sel_next     = SEL_IDLE;
          ptr_next     = ptr_after;
          stall_next   = '0;
          timeout_next = 1'b1;
        end else begin
          stall_next = stall_inc;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    credits_next    = credits;
    credit_err_next = 1'b0;
    if (fwd && !credit_in) begin
      credits_next = credits - 3'd1;
    end else if (credit_in && !fwd) begin
      if (credits == DEPTH_C) credit_err_next = 1'b1;
      else                    credits_next    = credits + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      grant      <= '0;
      sel        <= SEL_IDLE;
      ptr        <= '0;
      credits    <= DEPTH_C;
      stall_cnt  <= '0;
      timeout    <= 1'b0;
      credit_err <= 1'b0;
    end else begin
      state      <= state_next;
      grant      <= grant_next;
      sel        <= sel_next;
      ptr        <= ptr_next;
      credits    <= credits_next;
      stall_cnt  <= stall_next;
      timeout    <= timeout_next;
      credit_err <= credit_err_next;
    end
  end

endmodule

// File: doc/rr_output_port_arbiter.md
Name: rr_output_port_arbiter

Overview:
Per-output-port wormhole arbiter for the 5-port router (ports L, N, E, W, S). It grants one output port to one input at a time using round-robin priority, and holds the grant until that packet's tail flit has been forwarded. It also tracks downstream buffer credits, and releases a stalled grant through a watchdog timeout. One instance sits beside each output of the crossbar and drives that output's select lines.

Parameters:
DEPTH, 4, downstream buffer depth in flits; initial and maximum credit count (range 1..7).
TIMEOUT, 16, consecutive BUSY cycles without a forward before the grant is forcibly released (range 1..255).

Ports:
clk  input  1  clock; all state is updated on the rising edge.
rst  input  1  reset; one clock; reset is asynchronous and active-low.
req  input  5  per-input request for this output; bit order [0]=L, [1]=N, [2]=E, [3]=W, [4]=S.
flit_valid  input  5  input i presents a flit this cycle.
flit_id  input  15  3-bit flit id per input; input i uses bits [3i+2:3i]. 3'b001 = header, bit2 = tail, so 3'b101 is a single-flit packet.
credit_in  input  1  one-cycle pulse: downstream has freed one buffer slot.
grant  output  5  one-hot grant (registered); all zeros when idle.
sel  output  3  encoded index of the granted input (0..4); 3'b111 when idle (registered).
busy  output  1  1 in state BUSY.
fwd  output  1  combinational; the flit from the granted input is transferred this cycle.
credits  output  3  current credit count.
timeout  output  1  one-cycle pulse when the watchdog releases a grant.
credit_err  output  1  one-cycle pulse when credit_in arrives while credits == DEPTH.

Behaviour:
- Reset (rst=0, asynchronous, takes effect immediately):
  - state = IDLE, grant = 0, sel = 3'b111.
  - Round-robin pointer ptr = 0 (L).
  - credits = DEPTH, stall counter = 0, timeout = 0, credit_err = 0.
- IDLE:
  - If req != 0, choose the first set bit scanning ptr, ptr+1, ... mod 5.
  - On the next edge: grant = onehot(winner), sel = winner, state = BUSY.
  - Grant latency is 1 cycle from req being sampled. If req == 0, stay in IDLE.
- BUSY, with g = granted index:
  - fwd = flit_valid[g] & (credits != 0). The other inputs' req and valid are ignored.
  - If fwd and flit_id[g] bit2 = 1 (tail): on the edge, state = IDLE, grant = 0, sel = 3'b111, ptr = (g+1) mod 5.
  - The cycle after the tail is always an IDLE arbitration cycle, so there is a 1-cycle bubble between packets.
  - req[g] dropping mid-packet does not release the grant; only a forwarded tail or a timeout does.
- fwd is forced to 0 in IDLE.
- Credits:
  - On an edge: fwd & !credit_in gives -1; credit_in & !fwd gives +1; both together leave credits unchanged.
  - credit_in at credits == DEPTH with no fwd: credits stay at DEPTH and credit_err pulses for 1 cycle.
  - credits never underflow, because fwd requires credits != 0.
- Watchdog:
  - The 8-bit stall counter increments on each BUSY cycle with fwd = 0, and clears to 0 on fwd or in IDLE.
  - When the counter reaches TIMEOUT (checked at the edge where the increment would produce TIMEOUT):
    - state = IDLE, grant = 0, ptr = (g+1) mod 5, counter = 0.
    - timeout = 1 for the following cycle.
  - A stall caused by zero credits also counts toward the timeout.
- The tail being forwarded on the same cycle the watchdog would fire: the tail wins (normal release, no timeout).
- timeout and credit_err default to 0 every cycle unless set.

Test Plan:
1. Reset, req=5'b00001 held: grant = 00001 and sel = 0 one cycle later. Then send L flits 001, 000, 100 with flit_valid=1 → fwd on 3 cycles, credits 4→1, grant = 0 the cycle after the tail.
2. req=5'b11111 held, every input sending single-flit packets (3'b101), credit_in pulsing each fwd → grant sequence L, N, E, W, S, L, each separated by one idle cycle.
3. DEPTH=4, grant E, 5 body flits valid, no credit_in → fwd on 4 cycles, credits = 0, fwd = 0 on the 5th; one credit_in pulse → the 5th flit forwards on the following cycle.
4. credits = 2, fwd and credit_in in the same cycle → credits stay 2. credit_in at credits = 4 while idle → credits stay 4 and credit_err pulses once.
5. Grant N, flit_valid = 0 for 16 cycles → timeout pulse once, grant = 0, busy = 0. Then req=5'b00011 → next grant is L (ptr=2 has no request, scan wraps to L).
6. rst=0 asserted mid-packet, asynchronously between edges → grant = 0, sel = 7, credits = 4 immediately. After rst=1 with req=5'b00100 → grant = 00100 on the first edge.
